product_accumulator: RTL and testbench

Downstream consumer of the `Multiplier` product stream. Accepts signed products one per cycle over a valid/ready handshake and sums a fixed block of `COUNT` products into a wider accumulator. Presents the block sum, with a sticky overflow flag, on a valid/ready output port. Forms the accumulate half of the dot-product datapath.

---
 rtl/product_accumulator.sv | 99 +++++++++
 tb/tb_product_accumulator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Block accumulator for the multiplier product stream: sums COUNT signed
// products into a wide accumulator and presents the sum with a sticky overflow flag.
module product_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int COUNT     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     product,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_sum,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 add_ovf;
  logic                 last_beat;

  // Sign-extend through a signed size cast so ACC_WIDTH == WIDTH is legal.
  assign prod_ext  = ACC_WIDTH'($signed(product));
  assign sum       = acc_q + prod_ext;
  assign add_ovf   = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign last_beat = (cnt_q == CNT_W'(COUNT - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        // clear wins over a same-cycle accept; that product is dropped.
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | add_ovf;
          if (last_beat) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode only from state, so no input-to-output path exists.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign acc_sum   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: a behavioural model pushes block
// results to a queue, and a monitor pops and compares them at each output handshake.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] product;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] acc_sum;
  logic        overflow;

  logic        o_in_valid;
  logic        o_in_ready;
  logic [31:0] o_product;
  logic        o_clear;
  logic        o_out_valid;
  logic        o_out_ready;
  logic [31:0] o_acc_sum;
  logic        o_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [39:0] acc;
    logic        ovf;
  } result_t;

  result_t     sb[$];
  longint      model_acc;
  int          model_cnt;
  logic        model_ovf;

  product_accumulator #(.WIDTH(32), .ACC_WIDTH(40), .COUNT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .acc_sum(acc_sum), .overflow(overflow)
  );

  product_accumulator #(.WIDTH(32), .ACC_WIDTH(32), .COUNT(2)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .product(o_product), .clear(o_clear), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .acc_sum(o_acc_sum), .overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Model of the 40-bit accumulator using true integer range to detect overflow.
  task automatic model_reset();
    model_acc = 0;
    model_cnt = 0;
    model_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [31:0] p);
    longint s;
    logic [39:0] w;
    s = model_acc + longint'($signed(p));
    if (s > 64'sd549755813887 || s < -64'sd549755813888) model_ovf = 1'b1;
    w = s[39:0];
    model_acc = longint'($signed(w));
    model_cnt++;
    if (model_cnt == 8) begin
      sb.push_back('{acc: w, ovf: model_ovf});
      model_reset();
    end
  endtask

  // Drive one product and hold it until the DUT accepts it.
  task automatic send(input logic [31:0] p);
    int guard = 0;
    in_valid = 1'b1;
    product  = p;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(p);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        result_t r;
        r = sb.pop_front();
        check("sb_acc_sum", 64'(acc_sum), 64'(r.acc));
        check("sb_overflow", 64'(overflow), 64'(r.ovf));
        $display("result acc_sum=%0d overflow=%0b", $signed(acc_sum), overflow);
      end
    end
  end

  initial begin
    int gap;
    logic signed [31:0] sv [8] = '{-3, 7, -100, 50, 0, -1, 2, 45};
    rst = 1'b1; in_valid = 1'b0; product = '0; clear = 1'b0; out_ready = 1'b1;
    o_in_valid = 1'b0; o_product = '0; o_clear = 1'b0; o_out_ready = 1'b0;
    model_reset();

    // Reset with a live product on the input.
    @(posedge clk); #1;
    in_valid = 1'b1; product = 32'd5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_acc_sum", 64'(acc_sum), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_nothing_accum", 64'(acc_sum), 64'd0);
    @(posedge clk); #1;

    // Basic block 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) send(32'(i));
    @(negedge clk);
    check("basic_out_valid", 64'(out_valid), 64'd1);
    check("basic_in_ready_low", 64'(in_ready), 64'd0);
    check("basic_sum_36", 64'(acc_sum), 64'd36);
    @(negedge clk);
    check("basic_one_cycle", 64'(out_valid), 64'd0);
    check("basic_next_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Signed values with random gaps, then 5 cycles of backpressure.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
      send(sv[i]);
    end
    in_valid = 1'b1; product = 32'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_acc_sum", 64'(acc_sum), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    idle(2);

    // Clear drops partial block and the coincident product.
    for (int i = 0; i < 3; i++) send(32'd10);
    clear = 1'b1; in_valid = 1'b1; product = 32'd99;
    idle(1);
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("clear_zero", 64'(acc_sum), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'd1);
    clear = 1'b1;
    idle(2);
    @(negedge clk);
    check("hold_clear_valid", 64'(out_valid), 64'd1);
    check("hold_clear_sum_8", 64'(acc_sum), 64'd8);
    @(posedge clk); #1;
    clear = 1'b0; out_ready = 1'b1;
    idle(2);

    // Reset after 5 accepts.
    for (int i = 0; i < 5; i++) send(32'd2);
    do_reset(1);
    @(negedge clk);
    check("midrst_acc", 64'(acc_sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Reset while holding a result.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'd2);
    @(negedge clk);
    check("pre_rst_hold", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    do_reset(1);
    @(negedge clk);
    check("holdrst_out_valid", 64'(out_valid), 64'd0);
    check("holdrst_acc", 64'(acc_sum), 64'd0);
    check("holdrst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'd2);
    @(negedge clk);
    check("fresh_sum_16", 64'(acc_sum), 64'd16);
    @(posedge clk); #1;
    idle(2);

    // Overflow on the narrow instance.
    o_in_valid = 1'b1; o_product = 32'h7FFF_FFFF;
    @(negedge clk);
    check("ovf_in_ready", 64'(o_in_ready), 64'd1);
    @(posedge clk); #1;
    o_product = 32'h0000_0001;
    idle(1);
    o_in_valid = 1'b0;
    @(negedge clk);
    check("ovf_out_valid", 64'(o_out_valid), 64'd1);
    check("ovf_sum", 64'(o_acc_sum), 64'h8000_0000);
    check("ovf_flag", 64'(o_overflow), 64'd1);
    $display("ovf block acc_sum=0x%0h overflow=%0b", o_acc_sum, o_overflow);
    @(posedge clk); #1;
    o_out_ready = 1'b1;
    idle(1);
    o_out_ready = 1'b0;
    o_in_valid = 1'b1; o_product = 32'd1;
    idle(2);
    o_in_valid = 1'b0;
    @(negedge clk);
    check("ovf_next_valid", 64'(o_out_valid), 64'd1);
    check("ovf_next_sum", 64'(o_acc_sum), 64'd2);
    check("ovf_next_flag", 64'(o_overflow), 64'd0);
    $display("ovf next block acc_sum=0x%0h overflow=%0b", o_acc_sum, o_overflow);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
